// File: rtl/mavg_pkg.sv
// Shared types and helpers for the multi-channel moving-average filter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mavg_pkg;

  typedef enum logic {
    MODE_AVG = 1'b0,
    MODE_SUM = 1'b1
  } mode_e;

  // A window of 2**depth_log2 samples of w bits sums to at most
  // (2**depth_log2)*(2**w-1), which fits exactly in w+depth_log2 bits.
  function automatic int sum_width(input int w, input int depth_log2);
    return w + depth_log2;
  endfunction

endpackage

// File: rtl/mavg_channel.sv
// One channel of the moving-average filter: delay line, running sum, rounded mean.
// Latency: sum/avg reflect an accepted sample one cycle after the accepting edge.
// Backpressure: none; a sample is taken on every in_valid edge unless clear is high.
// Ports: clk, rst_n (async, active-high), clear, in_valid, in_sample [W],
//        sum_o [SW] raw window sum, avg_o [SW] rounded mean zero-extended.
module mavg_channel
  import mavg_pkg::*;
#(
  parameter int W          = 2,
  parameter int DEPTH_LOG2 = 2,
  localparam int SW        = sum_width(W, DEPTH_LOG2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [W-1:0]  in_sample,
  output logic [SW-1:0] sum_o,
  output logic [SW-1:0] avg_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [SW-1:0] HALF = SW'(1) << (DEPTH_LOG2 - 1);

  logic [W-1:0]  taps_q [DEPTH];
  logic [W-1:0]  taps_d [DEPTH];
  logic [SW-1:0] sum_q;
  logic [SW-1:0] sum_d;
  logic [SW-1:0] rnd;

  always_comb begin
    taps_d = taps_q;
    sum_d  = sum_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) taps_d[i] = '0;
      sum_d = '0;
    end else if (in_valid) begin
      // The oldest tap is always part of sum_q, so the subtraction never underflows.
      sum_d = sum_q + SW'(in_sample) - SW'(taps_q[DEPTH-1]);
      for (int i = DEPTH - 1; i > 0; i--) taps_d[i] = taps_q[i-1];
      taps_d[0] = in_sample;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) taps_q[i] <= '0;
      sum_q <= '0;
    end else begin
      taps_q <= taps_d;
      sum_q  <= sum_d;
    end
  end

  // sum + DEPTH/2 peaks at DEPTH*2**W - DEPTH/2, still inside SW bits.
  assign rnd   = sum_q + HALF;
  assign sum_o = sum_q;
  assign avg_o = rnd >> DEPTH_LOG2;

endmodule

// File: rtl/moving_avg_multich.sv
// CH-channel moving-average filter over a 2**DEPTH_LOG2 window, raw sum or rounded mean.
// Latency: out_valid and out_data reflect an accepted sample one cycle after acceptance.
// Backpressure: none; in_valid is always accepted unless clear is high.
// Ports: clk, rst_n (async, active-high), clear, in_valid, in_data [CH*W],
//        mode (0 avg / 1 sum), out_en (gate), out_valid, out_full, out_data [CH*SW].
module moving_avg_multich
  import mavg_pkg::*;
#(
  parameter int CH         = 3,
  parameter int W          = 2,
  parameter int DEPTH_LOG2 = 2,
  localparam int SW        = sum_width(W, DEPTH_LOG2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [CH*W-1:0]  in_data,
  input  logic             mode,
  input  logic             out_en,
  output logic             out_valid,
  output logic             out_full,
  output logic [CH*SW-1:0] out_data
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(1 << DEPTH_LOG2);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          out_valid_q;
  logic          out_valid_d;

  always_comb begin
    count_d     = count_q;
    out_valid_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      if (count_q != DEPTH_CNT) count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_full  = (count_q == DEPTH_CNT);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [SW-1:0] ch_sum;
    logic [SW-1:0] ch_avg;

    mavg_channel #(
      .W          (W),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_sample (in_data[c*W +: W]),
      .sum_o     (ch_sum),
      .avg_o     (ch_avg)
    );

    // Mode and gate act combinationally so a change shows in the same cycle.
    assign out_data[c*SW +: SW] = !out_en                      ? '0     :
                                  (mode_e'(mode) == MODE_SUM)  ? ch_sum : ch_avg;
  end

endmodule

// File: tb/tb_moving_avg_multich.sv
module tb_moving_avg_multich;

  localparam int CH    = 3;
  localparam int W     = 2;
  localparam int DL    = 2;
  localparam int DEPTH = 4;
  localparam int SW    = W + DL;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic [CH*W-1:0]  in_data;
  logic             mode;
  logic             out_en;
  logic             out_valid;
  logic             out_full;
  logic [CH*SW-1:0] out_data;

  moving_avg_multich #(.CH(CH), .W(W), .DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .mode      (mode),
    .out_en    (out_en),
    .out_valid (out_valid),
    .out_full  (out_full),
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Model: the list of accepted sample vectors since reset/clear, plus the
  // valid flag of the last edge. Window sums come from the last DEPTH entries.
  logic [CH*W-1:0] accepted[$];
  bit              m_valid;

  function automatic int m_sum(input int c);
    int s = 0;
    int n = accepted.size();
    for (int k = 0; k < DEPTH && k < n; k++) begin
      logic [CH*W-1:0] v = accepted[n-1-k];
      s += int'(v[c*W +: W]);
    end
    return s;
  endfunction

  function automatic int m_out(input int c);
    int s = m_sum(c);
    if (!out_en) return 0;
    if (mode) return s;
    return (s + DEPTH / 2) / DEPTH;
  endfunction

  function automatic int chan(input int c);
    logic [CH*SW-1:0] v = out_data;
    return int'(v[c*SW +: SW]);
  endfunction

  task automatic model_reset();
    accepted.delete();
    m_valid = 1'b0;
  endtask

  // Model update on the edge, using inputs that were stable across it.
  task automatic model_edge();
    if (rst_n) return;
    if (clear) begin
      accepted.delete();
      m_valid = 1'b0;
    end else if (in_valid) begin
      accepted.push_back(in_data);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_out_valid", int'(out_valid), int'(m_valid));
      chk("cmp_out_full", int'(out_full), int'(accepted.size() >= DEPTH));
      for (int c = 0; c < CH; c++) chk($sformatf("cmp_data_ch%0d", c), chan(c), m_out(c));
    end
  end

  function automatic logic [CH*W-1:0] pack3(input int a, input int b, input int c);
    logic [CH*W-1:0] v;
    v[0 +: W]   = W'(a);
    v[W +: W]   = W'(b);
    v[2*W +: W] = W'(c);
    return v;
  endfunction

  // Drive inputs, clock one edge, update the model, then settle mid-low phase.
  task automatic step(input bit v, input int a, input int b, input int c, input bit clr);
    in_valid = v;
    in_data  = pack3(a, b, c);
    clear    = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    mode     = 1'b1;
    out_en   = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_full", int'(out_full), 0);
    chk("reset_data", int'(out_data), 0);
    rst_n  = 1'b0;
    cmp_en = 1'b1;

    // Warm-up in SUM mode: ch0 = 3 each cycle.
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b1, 3, 0, 0, 1'b0);
      chk($sformatf("warm_sum%0d", k), chan(0), 3 * k);
      chk($sformatf("warm_full%0d", k), int'(out_full), int'(k == DEPTH));
    end

    // Steady state in AVG mode: window 3,3,3,3 then 0, 1.
    mode = 1'b0;
    #1;
    chk("avg_12", chan(0), 3);
    step(1'b1, 0, 0, 0, 1'b0);
    chk("avg_9", chan(0), 2);
    step(1'b1, 1, 0, 0, 1'b0);
    chk("avg_7", chan(0), 2);

    // Gaps: ch1 = 2 with in_valid 1,0,1.
    mode = 1'b1;
    step(1'b1, 0, 2, 0, 1'b0);
    chk("gap_v1", int'(out_valid), 1);
    chk("gap_s1", chan(1), 2);
    step(1'b0, 0, 2, 0, 1'b0);
    chk("gap_v0", int'(out_valid), 0);
    chk("gap_s0", chan(1), 2);
    step(1'b1, 0, 2, 0, 1'b0);
    chk("gap_v2", int'(out_valid), 1);
    chk("gap_s2", chan(1), 4);

    // Fill ch1 with 3s, then clear beats a simultaneous sample.
    repeat (DEPTH) step(1'b1, 0, 3, 0, 1'b0);
    chk("full_sum", chan(1), 12);
    step(1'b1, 0, 3, 0, 1'b1);
    chk("clr_sum", chan(1), 0);
    chk("clr_full", int'(out_full), 0);
    chk("clr_valid", int'(out_valid), 0);
    step(1'b1, 0, 2, 0, 1'b0);
    chk("post_clr_sum", chan(1), 2);
    chk("post_clr_valid", int'(out_valid), 1);

    // Gating and channel separation with inputs 1/2/3.
    out_en = 1'b0;
    step(1'b1, 1, 2, 3, 1'b0);
    chk("gate_off_a", int'(out_data), 0);
    step(1'b1, 1, 2, 3, 1'b0);
    chk("gate_off_b", int'(out_data), 0);
    out_en = 1'b1;
    #1;
    chk("gate_on_ch0", chan(0), 2);
    chk("gate_on_ch1", chan(1), 6);
    chk("gate_on_ch2", chan(2), 6);
    step(1'b1, 1, 2, 3, 1'b0);
    mode = 1'b0;
    #1;
    chk("sep_avg_ch0", chan(0), 1);
    chk("sep_avg_ch1", chan(1), 2);
    chk("sep_avg_ch2", chan(2), 2);

    // Async reset mid-stream, checked between edges.
    mode = 1'b1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("async_valid", int'(out_valid), 0);
    chk("async_full", int'(out_full), 0);
    chk("async_data", int'(out_data), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    step(1'b1, 3, 0, 0, 1'b0);
    chk("after_rst_sum", chan(0), 3);
    chk("after_rst_full", int'(out_full), 0);

    step(1'b0, 0, 0, 0, 1'b0);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
